// File: rtl/image_frame_writer_pkg.sv
// Shared types and constants for the image frame writer: FSM states, AXI response
// and burst encodings, and the AWSIZE derivation from the data width.
package image_frame_writer_pkg;

  localparam int unsigned FRAME_W = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_DONE
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // AXI size code: log2 of bytes per beat.
  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/image_frame_writer_if.sv
// AXI4 write-only channel bundle (AW, W, B) between the frame writer and the
// memory interconnect.
interface image_frame_writer_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/frame_word_fifo.sv
// Synchronous first-word-fall-through word FIFO with occupancy count and a
// synchronous flush; a push into a full FIFO succeeds when a pop happens that cycle.
module frame_word_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_pop   = pop && !empty && !flush;
  assign do_push  = push && (!full || do_pop) && !flush;
  assign pop_data = mem[rd_ptr];
  assign count    = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/image_frame_writer.sv
// Camera-to-memory frame writer: packs pixels into words, buffers them and writes
// one frame as AXI4 INCR bursts. IMAGE_FRAME_WRITER_PTGEN_EN adds a counting test-pattern source.
module image_frame_writer
  import image_frame_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned PIX_WIDTH  = 16,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  INIT_AXI_TXN,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [FRAME_W-1:0]    frame_words,
  input  logic                  test_mode,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [PIX_WIDTH-1:0]  pix_data,
  image_frame_writer_if.master  m_axi,
  output logic                  TXN_DONE,
  output logic                  ERROR
);

  localparam int unsigned LANES      = DATA_WIDTH / PIX_WIDTH;
  localparam int unsigned LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BEAT_W     = 9;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [FRAME_W-1:0]      remaining_q;
  logic [FRAME_W-1:0]      frame_words_q;
  logic [FRAME_W-1:0]      words_pushed_q;
  logic [BEAT_W-1:0]       beats_q;
  logic [BEAT_W-1:0]       burst;

  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [7:0]              awlen_q;
  logic                    awvalid_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    wlast_q;
  logic                    wvalid_q;
  logic                    bready_q;
  logic                    done_q;
  logic                    error_q;

  logic [LANE_W-1:0]       lane_q;
  logic [DATA_WIDTH-1:0]   pack_q;
  logic [DATA_WIDTH-1:0]   push_word;
  logic                    start;
  logic                    active;
  logic                    space;
  logic                    accept;
  logic                    word_done;
  logic                    src_valid;
  logic [PIX_WIDTH-1:0]    src_data;

  logic                    fifo_pop;
  logic [DATA_WIDTH-1:0]   fifo_data;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign start  = INIT_AXI_TXN && (state == ST_IDLE || state == ST_DONE);
  assign burst  = (remaining_q >= FRAME_W'(BURST_LEN)) ? BEAT_W'(BURST_LEN) : BEAT_W'(remaining_q);
  assign active = (state == ST_ADDR || state == ST_DATA || state == ST_RESP) &&
                  (words_pushed_q != frame_words_q);

  // A beat moves from the FIFO into the W register whenever that register frees up.
  assign fifo_pop = (state == ST_DATA) && (beats_q < burst) && !fifo_empty &&
                    (!wvalid_q || m_axi.wready);
  assign space    = !fifo_full || fifo_pop;

`ifdef IMAGE_FRAME_WRITER_PTGEN_EN
  logic [PIX_WIDTH-1:0] gen_q;

  assign src_valid = test_mode ? 1'b1  : pix_valid;
  assign src_data  = test_mode ? gen_q : pix_data;
  assign pix_ready = active && space && !test_mode;
`else
  logic unused_test_mode;

  assign unused_test_mode = test_mode;
  assign src_valid        = pix_valid;
  assign src_data         = pix_data;
  assign pix_ready        = active && space;
`endif

  assign accept    = active && space && src_valid;
  assign word_done = accept && (lane_q == LANE_W'(LANES - 1));

  // Current partial word with the incoming pixel dropped into its lane.
  always_comb begin
    push_word = pack_q;
    for (int i = 0; i < int'(LANES); i++) begin
      if (lane_q == LANE_W'(i)) push_word[i*PIX_WIDTH +: PIX_WIDTH] = src_data;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      lane_q         <= '0;
      pack_q         <= '0;
      words_pushed_q <= '0;
      frame_words_q  <= '0;
`ifdef IMAGE_FRAME_WRITER_PTGEN_EN
      gen_q          <= '0;
`endif
    end else if (start) begin
      lane_q         <= '0;
      pack_q         <= '0;
      words_pushed_q <= '0;
      frame_words_q  <= frame_words;
`ifdef IMAGE_FRAME_WRITER_PTGEN_EN
      gen_q          <= '0;
`endif
    end else if (accept) begin
      pack_q <= push_word;
      lane_q <= word_done ? '0 : lane_q + LANE_W'(1);
      if (word_done) words_pushed_q <= words_pushed_q + FRAME_W'(1);
`ifdef IMAGE_FRAME_WRITER_PTGEN_EN
      if (test_mode) gen_q <= gen_q + PIX_WIDTH'(1);
`endif
    end
  end

  frame_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .flush     (start),
    .push      (word_done),
    .push_data (push_word),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Burst sequencer: one AW, its W beats, then its B before the next burst.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wlast_q     <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (INIT_AXI_TXN) begin
            addr_q      <= base_addr;
            remaining_q <= frame_words;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            state       <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (awvalid_q) begin
            if (m_axi.awready) begin
              awvalid_q <= 1'b0;
              beats_q   <= '0;
              state     <= ST_DATA;
            end
          end else if (32'(fifo_count) >= 32'(burst)) begin
            awvalid_q <= 1'b1;
            awaddr_q  <= addr_q;
            awlen_q   <= 8'(burst - BEAT_W'(1));
          end
        end
        ST_DATA: begin
          if (fifo_pop) begin
            wvalid_q <= 1'b1;
            wdata_q  <= fifo_data;
            wlast_q  <= (beats_q == burst - BEAT_W'(1));
            beats_q  <= beats_q + BEAT_W'(1);
          end else if (wvalid_q && m_axi.wready) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
          end
          if (wvalid_q && m_axi.wready && wlast_q) begin
            bready_q <= 1'b1;
            state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (m_axi.bvalid) begin
            bready_q    <= 1'b0;
            if (m_axi.bresp != RESP_OKAY) error_q <= 1'b1;
            addr_q      <= addr_q + (ADDR_WIDTH'(burst) << BYTE_SHIFT);
            remaining_q <= remaining_q - FRAME_W'(burst);
            if (remaining_q == FRAME_W'(burst)) begin
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              state  <= ST_ADDR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = awlen_q;
  assign m_axi.awsize  = axi_size(DATA_WIDTH);
  assign m_axi.awburst = BURST_INCR;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wlast_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign TXN_DONE      = done_q;
  assign ERROR         = error_q;

endmodule
